// File: rtl/layer_event_bridge.sv
// Event bridge between a conv/pool layer output port and the next layer's input stream.
// Filters empty events and duplicate timestep markers, buffers words, widens coordinates, counts transfers.
module layer_event_bridge #(
   parameter int IN_COORD_BITS  = 4,
   parameter int OUT_COORD_BITS = 5,
   parameter int CHANNELS       = 4,
   parameter int FIFO_DEPTH     = 16,
   parameter int CNT_WIDTH      = 16,
   localparam int W_IN  = 2*IN_COORD_BITS + CHANNELS + 1,
   localparam int W_OUT = 2*OUT_COORD_BITS + CHANNELS + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 in_write_enable,
   input  logic [W_IN-1:0]      in_data,
   output logic                 in_full_next,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [W_OUT-1:0]     out_data,
   output logic                 overflow,
   output logic [CNT_WIDTH-1:0] event_count,
   output logic [CNT_WIDTH-1:0] timestep_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] THR_C   = CW'(FIFO_DEPTH - 1);

   if (OUT_COORD_BITS < IN_COORD_BITS) begin : g_bad_coord
      $error("OUT_COORD_BITS must be >= IN_COORD_BITS");
   end
   if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two and >= 4");
   end

   typedef enum logic {EMPTY, FULL} state_t;

   state_t              state, state_nx;
   logic [W_IN-1:0]     mem [FIFO_DEPTH];
   logic [PW-1:0]       wr_ptr, rd_ptr;
   logic [CW-1:0]       count;
   logic                last_was_marker;
   logic                in_ts;
   logic [CHANNELS-1:0] in_spk;
   logic                storable, push, drop, pop, xfer;

   function automatic logic [W_OUT-1:0] repack(input logic [W_IN-1:0] w);
      logic [IN_COORD_BITS-1:0] x, y;
      x = w[CHANNELS+IN_COORD_BITS +: IN_COORD_BITS];
      y = w[CHANNELS +: IN_COORD_BITS];
      return {w[W_IN-1], OUT_COORD_BITS'(x), OUT_COORD_BITS'(y), w[CHANNELS-1:0]};
   endfunction

   assign in_ts        = in_data[W_IN-1];
   assign in_spk       = in_data[CHANNELS-1:0];
   assign storable     = in_write_enable && (in_ts || in_spk != '0) && !(in_ts && last_was_marker);
   // A full FIFO drops the write even if the output stage pops in the same cycle.
   assign push         = storable && (count != DEPTH_C);
   assign drop         = storable && (count == DEPTH_C);
   assign in_full_next = (count >= THR_C);
   assign out_valid    = (state == FULL);
   assign xfer         = out_valid && out_ready;

   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      case (state)
         EMPTY: begin
            if (enable && count != '0) begin
               pop      = 1'b1;
               state_nx = FULL;
            end
         end
         FULL: begin
            if (out_ready) begin
               if (enable && count != '0) pop = 1'b1;
               else                       state_nx = EMPTY;
            end
         end
         default: state_nx = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= EMPTY;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         count           <= '0;
         last_was_marker <= 1'b0;
         overflow        <= 1'b0;
         out_data        <= '0;
         event_count     <= '0;
         timestep_count  <= '0;
      end else begin
         state <= state_nx;
         if (storable) last_was_marker <= in_ts;
         if (drop)     overflow        <= 1'b1;
         if (push)     wr_ptr          <= wr_ptr + PW'(1);
         if (pop) begin
            rd_ptr   <= rd_ptr + PW'(1);
            out_data <= repack(mem[rd_ptr]);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (xfer) begin
            if (out_data[W_OUT-1]) timestep_count <= timestep_count + CNT_WIDTH'(1);
            else                   event_count    <= event_count + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_layer_event_bridge.sv
// Self-checking bench for layer_event_bridge: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_layer_event_bridge;

   localparam int IN = 4, OUT = 5, CH = 4, D = 16, CNTW = 16;
   localparam int WI = 2*IN + CH + 1;
   localparam int WO = 2*OUT + CH + 1;

   logic            clk = 1'b0;
   logic            rst_n, enable, in_write_enable, in_full_next, out_valid, out_ready, overflow;
   logic [WI-1:0]   in_data;
   logic [WO-1:0]   out_data;
   logic [CNTW-1:0] event_count, timestep_count;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [WI-1:0]   fq[$];
   bit              rv, lwm, ovf;
   logic [WO-1:0]   rw;
   logic [CNTW-1:0] ev, tsc;

   layer_event_bridge #(
      .IN_COORD_BITS(IN), .OUT_COORD_BITS(OUT), .CHANNELS(CH),
      .FIFO_DEPTH(D), .CNT_WIDTH(CNTW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .in_write_enable(in_write_enable), .in_data(in_data), .in_full_next(in_full_next),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .overflow(overflow), .event_count(event_count), .timestep_count(timestep_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [WI-1:0] mk(input logic ts, input logic [3:0] x, input logic [3:0] y,
                                        input logic [3:0] sp);
      return {ts, x, y, sp};
   endfunction

   function automatic logic [WO-1:0] repack_m(input logic [WI-1:0] w);
      return {w[12], 1'b0, w[11:8], 1'b0, w[7:4], w[3:0]};
   endfunction

   function automatic void model_reset();
      fq.delete();
      rv = 0; lwm = 0; ovf = 0; rw = '0; ev = '0; tsc = '0;
   endfunction

   // Advance the model by one clock edge using the inputs currently driven.
   function automatic void model_step();
      int sz;
      bit xf, pp, ts;
      sz = fq.size();
      xf = rv && out_ready;
      pp = enable && sz > 0 && (!rv || out_ready);
      if (xf) begin
         if (rw[WO-1]) tsc = tsc + 1'b1;
         else          ev  = ev + 1'b1;
      end
      if (pp) begin
         rw = repack_m(fq.pop_front());
         rv = 1;
      end else if (xf) begin
         rv = 0;
      end
      if (in_write_enable) begin
         ts = in_data[WI-1];
         if (!(!ts && in_data[3:0] == 4'd0) && !(ts && lwm)) begin
            lwm = ts;
            if (sz == D) ovf = 1;
            else         fq.push_back(in_data);
         end
      end
   endfunction

   task automatic check_all();
      chk("out_valid", 64'(out_valid), 64'(rv));
      if (rv) chk("out_data", 64'(out_data), 64'(rw));
      chk("in_full_next", 64'(in_full_next), 64'(fq.size() >= D - 1));
      chk("overflow", 64'(overflow), 64'(ovf));
      chk("event_count", 64'(event_count), 64'(ev));
      chk("timestep_count", 64'(timestep_count), 64'(tsc));
   endtask

   // Drive one cycle of inputs at the negedge, clock it, then check at the next negedge.
   task automatic cyc(input logic we, input logic [WI-1:0] d, input logic rdy, input logic en);
      in_write_enable = we;
      in_data         = d;
      out_ready       = rdy;
      enable          = en;
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_data"}, 64'(out_data), 64'd0);
      chk({tag, "_full"}, 64'(in_full_next), 64'd0);
      chk({tag, "_ovf"}, 64'(overflow), 64'd0);
      chk({tag, "_ev"}, 64'(event_count), 64'd0);
      chk({tag, "_ts"}, 64'(timestep_count), 64'd0);
   endtask

   initial begin
      logic [CNTW-1:0] ev0;
      rst_n = 1'b0; enable = 1'b1; in_write_enable = 1'b0; in_data = '0; out_ready = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;

      // Single event: visible after the second edge, counted after the third.
      cyc(1'b1, mk(1'b0, 4'd3, 4'd9, 4'b0101), 1'b1, 1'b1);
      cyc(1'b0, '0, 1'b1, 1'b1);
      chk("single_valid", 64'(out_valid), 64'd1);
      chk("single_word", 64'(out_data), 64'(15'b0_00011_01001_0101));
      cyc(1'b0, '0, 1'b1, 1'b1);
      chk("single_evcnt", 64'(event_count), 64'd1);

      // Filtering: empty event and duplicate marker are dropped.
      cyc(1'b1, mk(1'b0, 4'd1, 4'd1, 4'd0), 1'b1, 1'b1);
      cyc(1'b1, mk(1'b1, 4'd0, 4'd0, 4'd0), 1'b1, 1'b1);
      cyc(1'b1, mk(1'b1, 4'd0, 4'd0, 4'd0), 1'b1, 1'b1);
      cyc(1'b1, mk(1'b0, 4'd2, 4'd2, 4'd1), 1'b1, 1'b1);
      cyc(1'b1, mk(1'b1, 4'd0, 4'd0, 4'd0), 1'b1, 1'b1);
      repeat (4) cyc(1'b0, '0, 1'b1, 1'b1);
      chk("filt_ts", 64'(timestep_count), 64'd2);
      chk("filt_ev", 64'(event_count), 64'd2);

      // Fill and overflow: 18 distinct events with downstream stalled.
      for (int i = 0; i < 18; i++) cyc(1'b1, mk(1'b0, 4'(i / 16), 4'(i % 16), 4'd1), 1'b0, 1'b1);
      chk("fill_full_next", 64'(in_full_next), 64'd1);
      chk("fill_overflow", 64'(overflow), 64'd1);
      chk("fill_held", 64'(fq.size() + (rv ? 1 : 0)), 64'd17);
      ev0 = event_count;
      repeat (20) cyc(1'b0, '0, 1'b1, 1'b1);
      chk("fill_drained", 64'(event_count - ev0), 64'd17);

      // Backpressure: out_ready toggles every cycle.
      ev0 = ev;
      for (int i = 0; i < 8; i++) cyc(1'b1, mk(1'b0, 4'(i), 4'(15 - i), 4'd2), 1'(i % 2), 1'b1);
      for (int i = 0; i < 20; i++) cyc(1'b0, '0, 1'(i % 2), 1'b1);
      chk("bp_evcnt", 64'(event_count), 64'(ev0 + 16'd8));

      // Enable gating: words accumulate without reaching the output stage.
      for (int i = 0; i < 3; i++) cyc(1'b1, mk(1'b0, 4'd7, 4'(i), 4'd8), 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("gate_valid_low", 64'(out_valid), 64'd0);
      cyc(1'b0, '0, 1'b1, 1'b1);
      chk("gate_valid_high", 64'(out_valid), 64'd1);
      repeat (4) cyc(1'b0, '0, 1'b1, 1'b1);

      // Asynchronous reset with words buffered.
      for (int i = 0; i < 5; i++) cyc(1'b1, mk(1'b0, 4'd5, 4'(i), 4'd3), 1'b0, 1'b1);
      in_write_enable = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_zero("midreset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) cyc(1'b0, '0, 1'b1, 1'b1);
      cyc(1'b1, mk(1'b0, 4'd9, 4'd4, 4'd6), 1'b1, 1'b1);
      chk("post_reset_lat1", 64'(out_valid), 64'd0);
      cyc(1'b0, '0, 1'b1, 1'b1);
      chk("post_reset_lat2", 64'(out_valid), 64'd1);
      chk("post_reset_word", 64'(out_data), 64'(15'b0_01001_00100_0110));

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         logic ts;
         logic [3:0] sp;
         ts = ($urandom % 4 == 0);
         sp = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom);
         cyc(1'($urandom % 3 != 0), {ts, 4'($urandom), 4'($urandom), sp},
             1'($urandom % 4 != 0), 1'($urandom % 8 != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
